avalon_uio_bridge: RTL and testbench

Avalon-MM slave that converts single-word HPS/lightweight-bridge transactions into the level-strobe `uio_bus` protocol consumed by the GPIO address decoder/register bank. It sits directly upstream of the decoder on the same `clklow` domain. It stretches read and write strobes long enough for the decoder's 3-stage strobe shift registers to see clean rising edges. It waits out the decoder's fixed read latency, returns `busdatain` with `waitrequest` flow control, and enforces an idle gap between transactions.

---
 rtl/uio_bridge_pkg.sv | 22 ++
 rtl/avalon_uio_bridge.sv | 152 +++++++++++++++
 tb/tb_avalon_uio_bridge.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/uio_bridge_pkg.sv
// Shared types and defaults for the Avalon-MM to uio_bus bridge.
// Imported by avalon_uio_bridge.
package uio_bridge_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR_STROBE,
    RD_STROBE,
    RD_WAIT,
    RD_DONE,
    GAP
  } bridge_state_t;

  localparam int DEF_STROBE  = 2;
  localparam int DEF_LATENCY = 5;
  localparam int DEF_GAP     = 2;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/avalon_uio_bridge.sv
// Avalon-MM slave that stretches single-word requests into
// level strobes for the uio_bus GPIO decoder.
module avalon_uio_bridge
  import uio_bridge_pkg::*;
#(
  parameter int AddrWidth     = 16,
  parameter int BusWidth      = 32,
  parameter int STROBE_CYCLES = DEF_STROBE,
  parameter int READ_LATENCY  = DEF_LATENCY,
  parameter int GAP_CYCLES    = DEF_GAP
) (
  input  logic                 clk,
  input  logic                 reset_in,
  input  logic [AddrWidth-1:0] avs_address,
  input  logic                 avs_read,
  input  logic                 avs_write,
  input  logic [BusWidth-1:0]  avs_writedata,
  output logic [BusWidth-1:0]  avs_readdata,
  output logic                 avs_waitrequest,
  output logic [AddrWidth-1:0] uio_address,
  output logic                 uio_read,
  output logic                 uio_write,
  output logic [BusWidth-1:0]  uio_busdataout,
  input  logic [BusWidth-1:0]  uio_busdatain,
  output logic                 proto_err
);

  localparam int CntW =
    $clog2(max_int(READ_LATENCY, GAP_CYCLES) + 1);

  localparam logic [CntW-1:0] StrobeLd =
    CntW'(STROBE_CYCLES - 1);
  localparam logic [CntW-1:0] WaitLd =
    CntW'(READ_LATENCY - STROBE_CYCLES - 1);
  localparam logic [CntW-1:0] GapLd =
    CntW'(GAP_CYCLES - 1);
  localparam logic [CntW-1:0] CntOne =
    CntW'(1);
  localparam logic [AddrWidth-1:0] WordMask =
    ~AddrWidth'(3);

  if (STROBE_CYCLES < 1) begin : g_bad_strobe
    $error("STROBE_CYCLES must be >= 1");
  end
  if (READ_LATENCY < STROBE_CYCLES + 1) begin : g_bad_lat
    $error("READ_LATENCY must be >= STROBE_CYCLES+1");
  end
  if (GAP_CYCLES < 1) begin : g_bad_gap
    $error("GAP_CYCLES must be >= 1");
  end

  bridge_state_t        state_q;
  logic [CntW-1:0]      cnt_q;
  logic [AddrWidth-1:0] addr_q;
  logic [BusWidth-1:0]  wdata_q;
  logic [BusWidth-1:0]  rdata_q;
  logic                 rd_q;
  logic                 wr_q;
  logic                 err_q;

  // Sequencer: strobe, wait out decoder latency, then idle gap.
  always_ff @(posedge clk or posedge reset_in) begin
    if (reset_in) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (avs_read) begin
            addr_q  <= avs_address & WordMask;
            cnt_q   <= StrobeLd;
            rd_q    <= 1'b1;
            state_q <= RD_STROBE;
            if (avs_write) err_q <= 1'b1;
          end else if (avs_write) begin
            addr_q  <= avs_address & WordMask;
            wdata_q <= avs_writedata;
            cnt_q   <= StrobeLd;
            wr_q    <= 1'b1;
            state_q <= WR_STROBE;
          end
        end
        WR_STROBE: begin
          if (cnt_q == '0) begin
            wr_q    <= 1'b0;
            cnt_q   <= GapLd;
            state_q <= GAP;
          end else begin
            cnt_q <= cnt_q - CntOne;
          end
        end
        RD_STROBE: begin
          if (cnt_q == '0) begin
            rd_q    <= 1'b0;
            cnt_q   <= WaitLd;
            state_q <= RD_WAIT;
          end else begin
            cnt_q <= cnt_q - CntOne;
          end
        end
        RD_WAIT: begin
          if (cnt_q == '0) begin
            rdata_q <= uio_busdatain;
            state_q <= RD_DONE;
          end else begin
            cnt_q <= cnt_q - CntOne;
          end
        end
        RD_DONE: begin
          cnt_q   <= GapLd;
          state_q <= GAP;
        end
        GAP: begin
          if (cnt_q == '0) begin
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q - CntOne;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Posted writes release in the accept cycle; reads in RD_DONE.
  always_comb begin
    avs_waitrequest = 1'b1;
    if (!reset_in) begin
      if (state_q == RD_DONE) begin
        avs_waitrequest = 1'b0;
      end else if (state_q == IDLE && avs_write && !avs_read) begin
        avs_waitrequest = 1'b0;
      end
    end
  end

  assign avs_readdata   = rdata_q;
  assign uio_address    = addr_q;
  assign uio_read       = rd_q;
  assign uio_write      = wr_q;
  assign uio_busdataout = wdata_q;
  assign proto_err      = err_q;

endmodule

// File: tb/tb_avalon_uio_bridge.sv
// Directed bench for avalon_uio_bridge with a small
// fixed-latency decoder read model.
module tb_avalon_uio_bridge;

  localparam logic [31:0] JUNK = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        reset_in = 1'b1;
  logic [15:0] avs_address = '0;
  logic        avs_read = 1'b0;
  logic        avs_write = 1'b0;
  logic [31:0] avs_writedata = '0;
  logic [31:0] avs_readdata;
  logic        avs_waitrequest;
  logic [15:0] uio_address;
  logic        uio_read;
  logic        uio_write;
  logic [31:0] uio_busdataout;
  logic [31:0] uio_busdatain = JUNK;
  logic        proto_err;

  int n_chk = 0;
  int n_fail = 0;

  logic [31:0] model_data = '0;
  int          mk = -1;
  logic        prev_rd = 1'b0;

  avalon_uio_bridge dut (
    .clk             (clk),
    .reset_in        (reset_in),
    .avs_address     (avs_address),
    .avs_read        (avs_read),
    .avs_write       (avs_write),
    .avs_writedata   (avs_writedata),
    .avs_readdata    (avs_readdata),
    .avs_waitrequest (avs_waitrequest),
    .uio_address     (uio_address),
    .uio_read        (uio_read),
    .uio_write       (uio_write),
    .uio_busdataout  (uio_busdataout),
    .uio_busdatain   (uio_busdatain),
    .proto_err       (proto_err)
  );

  always #5 clk = ~clk;

  // Decoder model: data valid only in the 4th cycle after the
  // uio_read rising edge, junk otherwise.
  always @(negedge clk) begin
    if (reset_in) begin
      mk = -1;
      prev_rd = 1'b0;
      uio_busdatain = JUNK;
    end else begin
      if (uio_read && !prev_rd) mk = 0;
      else if (mk >= 0) mk = mk + 1;
      uio_busdatain = (mk == 4) ? model_data : JUNK;
      if (mk > 4) mk = -1;
      prev_rd = uio_read;
    end
  end

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic run_write(input logic [15:0] a,
                           input logic [31:0] d,
                           input logic [15:0] ea);
    int nw;
    cyc();
    avs_address = a;
    avs_writedata = d;
    avs_write = 1'b1;
    #1;
    check("wr accept waitreq", 32'(avs_waitrequest), 0);
    nw = 0;
    for (int k = 1; k <= 8; k++) begin
      cyc();
      if (k == 1) begin
        avs_write = 1'b0;
        #1;
        check("wr uio_address", 32'(uio_address), 32'(ea));
        check("wr busdataout", uio_busdataout, d);
        check("wr waitreq T+1", 32'(avs_waitrequest), 1);
      end
      if (uio_write) nw++;
    end
    check("wr strobe width", nw, 2);
  endtask

  task automatic run_read(input logic [15:0] a,
                          input logic [31:0] d,
                          input logic [15:0] ea);
    int nlow, first, nr;
    logic [31:0] rd;
    model_data = d;
    cyc();
    avs_address = a;
    avs_read = 1'b1;
    #1;
    check("rd request waitreq", 32'(avs_waitrequest), 1);
    nlow = 0; first = 0; nr = 0; rd = '0;
    for (int k = 1; k <= 10; k++) begin
      cyc();
      if (k == 1)
        check("rd uio_address", 32'(uio_address), 32'(ea));
      if (uio_read) nr++;
      if (!avs_waitrequest) begin
        nlow++;
        if (first == 0) first = k;
        rd = avs_readdata;
        avs_read = 1'b0;
      end
    end
    check("rd waitreq low cycle", first, 6);
    check("rd waitreq low count", nlow, 1);
    check("rd readdata", rd, d);
    check("rd strobe width", nr, 2);
    check("rd readdata hold", avs_readdata, d);
  endtask

  typedef struct {
    bit          rd;
    logic [15:0] addr;
    logic [31:0] data;
    logic [15:0] ea;
  } vec_t;

  vec_t vt[5];

  initial begin
    int r1, r2, ovl, nw, nr, nlow;
    logic pw;
    logic [31:0] rd;

    vt[0] = '{1'b0, 16'h1100, 32'h00AB_CDEF, 16'h1100};
    vt[1] = '{1'b1, 16'h1304, 32'h1234_5678, 16'h1304};
    vt[2] = '{1'b0, 16'h1123, 32'hCAFE_F00D, 16'h1120};
    vt[3] = '{1'b1, 16'h2007, 32'hA5A5_5A5A, 16'h2004};
    vt[4] = '{1'b0, 16'hFFFF, 32'hFFFF_FFFF, 16'hFFFC};

    // reset state, waitrequest forced high even with a write
    avs_write = 1'b1;
    #12;
    check("reset waitreq", 32'(avs_waitrequest), 1);
    check("reset uio_read", 32'(uio_read), 0);
    check("reset uio_write", 32'(uio_write), 0);
    check("reset uio_address", 32'(uio_address), 0);
    check("reset busdataout", uio_busdataout, 0);
    check("reset readdata", avs_readdata, 0);
    check("reset proto_err", 32'(proto_err), 0);
    avs_write = 1'b0;
    cyc();
    reset_in = 1'b0;
    cyc();
    check("idle waitreq", 32'(avs_waitrequest), 1);
    check("idle uio_write", 32'(uio_write), 0);

    for (int i = 0; i < 5; i++) begin
      if (vt[i].rd) run_read(vt[i].addr, vt[i].data, vt[i].ea);
      else run_write(vt[i].addr, vt[i].data, vt[i].ea);
    end

    // back-to-back writes held asserted
    cyc();
    avs_address = 16'h0040;
    avs_writedata = 32'h5555_AAAA;
    avs_write = 1'b1;
    r1 = -1; r2 = -1; ovl = 0; pw = 1'b0; nlow = 0;
    for (int k = 0; k <= 10; k++) begin
      if (k > 0) cyc();
      #1;
      if (uio_write && !pw) begin
        if (r1 < 0) r1 = k;
        else if (r2 < 0) r2 = k;
      end
      if (uio_write && uio_read) ovl++;
      if (!avs_waitrequest) nlow++;
      pw = uio_write;
      if (k == 10) avs_write = 1'b0;
    end
    for (int k = 0; k < 8; k++) begin
      cyc();
      if (uio_write && uio_read) ovl++;
    end
    check("b2b first rise", r1, 1);
    check("b2b spacing", r2 - r1, 5);
    check("b2b accepts", nlow, 3);
    check("b2b overlap", ovl, 0);

    // read and write together: read wins, write dropped
    model_data = 32'h3333_4444;
    cyc();
    avs_address = 16'h1500;
    avs_writedata = 32'h1111_2222;
    avs_read = 1'b1;
    avs_write = 1'b1;
    #1;
    check("both waitreq", 32'(avs_waitrequest), 1);
    nw = 0; nr = 0; nlow = 0; rd = '0;
    for (int k = 1; k <= 10; k++) begin
      cyc();
      if (k == 1) check("both proto_err", 32'(proto_err), 1);
      if (uio_write) nw++;
      if (uio_read) nr++;
      if (!avs_waitrequest) begin
        nlow++;
        rd = avs_readdata;
        avs_read = 1'b0;
        avs_write = 1'b0;
      end
    end
    check("both no write", nw, 0);
    check("both read strobe", nr, 2);
    check("both one ack", nlow, 1);
    check("both readdata", rd, 32'h3333_4444);
    check("both busdataout kept", uio_busdataout, 32'h5555_AAAA);
    run_write(16'h0008, 32'h0000_0077, 16'h0008);
    check("proto_err sticky", 32'(proto_err), 1);

    // reset in RD_WAIT
    model_data = 32'h9999_0000;
    cyc();
    avs_address = 16'h1304;
    avs_read = 1'b1;
    for (int k = 1; k <= 4; k++) cyc();
    reset_in = 1'b1;
    #1;
    check("mid rst uio_read", 32'(uio_read), 0);
    check("mid rst readdata", avs_readdata, 0);
    check("mid rst waitreq", 32'(avs_waitrequest), 1);
    check("mid rst proto_err", 32'(proto_err), 0);
    avs_read = 1'b0;
    cyc();
    cyc();
    reset_in = 1'b0;
    cyc();
    check("post rst readdata", avs_readdata, 0);
    run_read(16'h1304, 32'h1234_5678, 16'h1304);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
